conv_window_gen: RTL and testbench

Streaming 3x3 sliding-window generator that sits directly upstream of the convolution core. It accepts one 8-bit Q1.6 pixel per cycle in raster order and buffers the two previous image rows in internal line buffers. Whenever the newest pixel completes a full 3x3 neighbourhood, it presents that neighbourhood as a `matrix_3x3_8bits` window. The convolution core consumes the window combinationally in the cycle it is valid; the block has no backpressure.

---
 rtl/conv_window_gen_if.sv | 55 +++++
 rtl/conv_window_gen.sv | 108 ++++++++++
 tb/tb_conv_window_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_gen_if.sv
// Shared window types and the pixel-in / window-out bus.
// master: pixel source + window consumer; slave: the generator.
package conv_window_pkg;
    typedef struct packed {
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
    } vector_3_8bits;

    typedef struct packed {
        vector_3_8bits vector0;
        vector_3_8bits vector1;
        vector_3_8bits vector2;
    } matrix_3x3_8bits;
endpackage

// Ports: pixel_i/pixel_valid_i (in to generator),
// window_o/window_valid_o/win_row_o/win_col_o/frame_done_o (out).
interface conv_window_gen_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
);
    import conv_window_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [7:0]      pixel_i;
    logic            pixel_valid_i;
    matrix_3x3_8bits window_o;
    logic            window_valid_o;
    logic [RW-1:0]   win_row_o;
    logic [CW-1:0]   win_col_o;
    logic            frame_done_o;

    modport master (
        output pixel_i,
        output pixel_valid_i,
        input  window_o,
        input  window_valid_o,
        input  win_row_o,
        input  win_col_o,
        input  frame_done_o
    );

    modport slave (
        input  pixel_i,
        input  pixel_valid_i,
        output window_o,
        output window_valid_o,
        output win_row_o,
        output win_col_o,
        output frame_done_o
    );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator with two line buffers.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module conv_window_gen
    import conv_window_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic             clk,
    input logic             rst,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      lb0_q [IMG_W];
    logic [7:0]      lb1_q [IMG_W];
    matrix_3x3_8bits win_q, win_d;
    logic            vld_q, vld_d;
    logic            done_q, done_d;
    logic [RW-1:0]   wrow_q, wrow_d;
    logic [CW-1:0]   wcol_q, wcol_d;

    logic       acc;
    logic [7:0] top_px;
    logic [7:0] mid_px;

    assign acc    = bus.pixel_valid_i;
    assign top_px = lb0_q[col_q];
    assign mid_px = lb1_q[col_q];

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        vld_d  = 1'b0;
        done_d = 1'b0;
        wrow_d = wrow_q;
        wcol_d = wcol_q;
        if (acc) begin
            win_d.vector0.p0 = win_q.vector0.p1;
            win_d.vector0.p1 = win_q.vector0.p2;
            win_d.vector0.p2 = top_px;
            win_d.vector1.p0 = win_q.vector1.p1;
            win_d.vector1.p1 = win_q.vector1.p2;
            win_d.vector1.p2 = mid_px;
            win_d.vector2.p0 = win_q.vector2.p1;
            win_d.vector2.p1 = win_q.vector2.p2;
            win_d.vector2.p2 = bus.pixel_i;
            // Columns 0/1 of a row still hold the
            // previous row's pixels, so no pulse there.
            vld_d  = (row_q >= RW'(2)) &&
                     (col_q >= CW'(2));
            done_d = (row_q == ROW_LAST) &&
                     (col_q == COL_LAST);
            if (vld_d) begin
                wrow_d = row_q - RW'(2);
                wcol_d = col_q - CW'(2);
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ?
                        '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            win_q  <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            wrow_q <= '0;
            wcol_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            win_q  <= win_d;
            vld_q  <= vld_d;
            done_q <= done_d;
            wrow_q <= wrow_d;
            wcol_q <= wcol_d;
        end
    end

    // Buffers are not cleared: rows 0-1 of every
    // frame refill them before any window is valid.
    always_ff @(posedge clk) begin
        if (!rst && acc) begin
            lb0_q[col_q] <= mid_px;
            lb1_q[col_q] <= bus.pixel_i;
        end
    end

    assign bus.window_o       = win_q;
    assign bus.window_valid_o = vld_q;
    assign bus.win_row_o      = wrow_q;
    assign bus.win_col_o      = wcol_q;
    assign bus.frame_done_o   = done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen at 4x4, 3x3 and 8x8.
// Model: windows cut directly from a stored image.
module tb_conv_window_gen;
    logic clk;
    logic rst;
    logic       pv [3];
    logic [7:0] px [3];

    logic [71:0] ow   [3];
    logic        ov   [3];
    logic        od   [3];
    logic [7:0]  orow [3];
    logic [7:0]  ocol [3];

    int W [3] = '{4, 3, 8};
    int H [3] = '{4, 3, 8};

    logic [7:0]  img [3][8][8];
    int          mr [3];
    int          mc [3];
    bit          hold [3];
    logic [71:0] lastw [3];
    int          wcnt [3];
    int          dcnt [3];

    int vectors;
    int miscompares;
    bit          g_on;
    int          g_frame;
    logic [71:0] g_val;

    conv_window_gen_if #(.IMG_W(4), .IMG_H(4)) b0 ();
    conv_window_gen_if #(.IMG_W(3), .IMG_H(3)) b1 ();
    conv_window_gen_if #(.IMG_W(8), .IMG_H(8)) b2 ();

    conv_window_gen #(.IMG_W(4), .IMG_H(4)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    conv_window_gen #(.IMG_W(3), .IMG_H(3)) u1 (
        .clk(clk), .rst(rst), .bus(b1));
    conv_window_gen #(.IMG_W(8), .IMG_H(8)) u2 (
        .clk(clk), .rst(rst), .bus(b2));

    assign b0.pixel_i = px[0];
    assign b1.pixel_i = px[1];
    assign b2.pixel_i = px[2];
    assign b0.pixel_valid_i = pv[0];
    assign b1.pixel_valid_i = pv[1];
    assign b2.pixel_valid_i = pv[2];

    assign ow[0] = b0.window_o;
    assign ow[1] = b1.window_o;
    assign ow[2] = b2.window_o;
    assign ov[0] = b0.window_valid_o;
    assign ov[1] = b1.window_valid_o;
    assign ov[2] = b2.window_valid_o;
    assign od[0] = b0.frame_done_o;
    assign od[1] = b1.frame_done_o;
    assign od[2] = b2.frame_done_o;
    assign orow[0] = 8'(b0.win_row_o);
    assign orow[1] = 8'(b1.win_row_o);
    assign orow[2] = 8'(b2.win_row_o);
    assign ocol[0] = 8'(b0.win_col_o);
    assign ocol[1] = 8'(b1.win_col_o);
    assign ocol[2] = 8'(b2.win_col_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k,
                       input logic [71:0] o,
                       input logic [71:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%h expected=%h",
                   tag, k, o, e);
        end
    endtask

    task automatic step(input logic r);
        logic [71:0] ew;
        logic ev;
        logic ed;
        int rr;
        int cc;
        rst = r;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            ev = 1'b0;
            ed = 1'b0;
            if (r) begin
                mr[k] = 0;
                mc[k] = 0;
                chk("rst_win", k, ow[k], 72'h0);
                chk("rst_row", k, 72'(orow[k]), 72'h0);
                chk("rst_col", k, 72'(ocol[k]), 72'h0);
                hold[k]  = 1'b1;
                lastw[k] = '0;
            end else if (pv[k]) begin
                rr = mr[k];
                cc = mc[k];
                img[k][rr][cc] = px[k];
                if (rr >= 2 && cc >= 2) begin
                    ev = 1'b1;
                    ed = (rr == H[k] - 1) &&
                         (cc == W[k] - 1);
                    ew = {img[k][rr-2][cc-2],
                          img[k][rr-2][cc-1],
                          img[k][rr-2][cc],
                          img[k][rr-1][cc-2],
                          img[k][rr-1][cc-1],
                          img[k][rr-1][cc],
                          img[k][rr][cc-2],
                          img[k][rr][cc-1],
                          img[k][rr][cc]};
                    chk("win", k, ow[k], ew);
                    chk("row", k, 72'(orow[k]),
                        72'(rr - 2));
                    chk("col", k, 72'(ocol[k]),
                        72'(cc - 2));
                    if (k == 0 && g_on && rr == 2 &&
                        cc == 2 && dcnt[0] == g_frame) begin
                        chk("golden", k, ow[k], g_val);
                        g_on = 1'b0;
                    end
                    lastw[k] = ew;
                end
                hold[k] = ev;
                if (cc == W[k] - 1) begin
                    mc[k] = 0;
                    mr[k] = (rr == H[k] - 1) ? 0 : rr + 1;
                end else begin
                    mc[k] = cc + 1;
                end
            end else if (hold[k]) begin
                chk("hold_win", k, ow[k], lastw[k]);
            end
            chk("valid", k, 72'(ov[k]), 72'(ev));
            chk("done", k, 72'(od[k]), 72'(ed));
            if (ov[k] === 1'b1) wcnt[k]++;
            if (od[k] === 1'b1) dcnt[k]++;
        end
    endtask

    // mode 0: frame*100+index, 1: random, 2: negative
    task automatic run_phase(input int mode,
                             input bit gaps,
                             input int frames,
                             input int abort_at);
        int rem [3];
        int sent [3];
        int n;
        bit busy;
        for (int k = 0; k < 3; k++) begin
            n = W[k] * H[k];
            rem[k]  = (abort_at > 0) ? abort_at
                                     : frames * n;
            sent[k] = 0;
            wcnt[k] = 0;
            dcnt[k] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            busy = 1'b0;
            for (int k = 0; k < 3; k++)
                if (rem[k] > 0) busy = 1'b1;
            if (!busy) break;
            for (int k = 0; k < 3; k++) begin
                n = W[k] * H[k];
                pv[k] = (rem[k] > 0) &&
                        (!gaps || $urandom_range(0, 1) == 1);
                case (mode)
                    0: px[k] = 8'((sent[k] / n) * 100 +
                                  sent[k] % n);
                    1: px[k] = 8'($urandom);
                    default: px[k] = 8'h80 | 8'($urandom);
                endcase
            end
            step(1'b0);
            for (int k = 0; k < 3; k++) begin
                if (pv[k]) begin
                    rem[k]--;
                    sent[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) pv[k] = 1'b0;
        repeat (3) step(1'b0);
        if (abort_at == 0) begin
            for (int k = 0; k < 3; k++) begin
                chk("win_count", k, 72'(wcnt[k]),
                    72'(frames * (W[k] - 2) * (H[k] - 2)));
                chk("frame_count", k, 72'(dcnt[k]),
                    72'(frames));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        g_on        = 1'b0;
        g_frame     = 0;
        g_val       = '0;
        rst         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pv[k]   = 1'b0;
            px[k]   = 8'h00;
            mr[k]   = 0;
            mc[k]   = 0;
            hold[k] = 1'b0;
            wcnt[k] = 0;
            dcnt[k] = 0;
        end
        step(1'b1);
        step(1'b1);

        g_on    = 1'b1;
        g_frame = 0;
        g_val   = 72'h000102_040506_08090a;
        run_phase(0, 1'b0, 1, 0);

        run_phase(0, 1'b1, 1, 0);

        g_on    = 1'b1;
        g_frame = 1;
        g_val   = 72'h646566_68696a_6c6d6e;
        run_phase(0, 1'b0, 2, 0);

        run_phase(0, 1'b0, 1, 10);
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b1;
            px[k] = 8'($urandom);
        end
        step(1'b1);
        step(1'b1);
        for (int k = 0; k < 3; k++) pv[k] = 1'b0;

        g_on    = 1'b1;
        g_frame = 0;
        g_val   = 72'h000102_040506_08090a;
        run_phase(0, 1'b0, 1, 0);

        run_phase(1, 1'b1, 2, 0);
        run_phase(2, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
